fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 134 +++++++++++++
 tb/tb_fetch_queue.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues sequential word fetches, buffers in-order responses in a
// circular queue and squashes in-flight responses after a redirect.
module fetch_queue #(
    parameter int unsigned          XLEN     = 32,
    parameter int unsigned          DEPTH    = 4,
    parameter logic [XLEN-1:0]      RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    output logic                     req_valid,
    output logic [XLEN-1:0]          req_addr,
    input  logic                     req_ready,
    input  logic                     rsp_valid,
    input  logic [31:0]              rsp_data,
    input  logic                     redirect_valid,
    input  logic [XLEN-1:0]          redirect_pc,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [31:0]              instr,
    output logic [XLEN-1:0]          instr_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    // Outstanding includes responses still to be dropped, which can exceed DEPTH.
    localparam int unsigned OW = 16;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [OW-1:0]   outstanding_q, outstanding_d;
    logic [OW-1:0]   drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;

    logic [31:0]     instr_mem_q [DEPTH];
    logic [XLEN-1:0] pc_mem_q    [DEPTH];

    logic [OW-1:0]   live;
    logic [OW-1:0]   occupancy;
    logic            req_fire;
    logic            rsp_drop;
    logic            push;
    logic            pop;

    // Live requests are those whose data will land in the queue; reserving room for them
    // guarantees a returning response always has a free slot.
    always_comb begin
        live        = outstanding_q - drop_cnt_q;
        occupancy   = OW'(count_q) + live;
        req_valid   = rst & enable & ~redirect_valid & (occupancy < OW'(DEPTH));
        req_fire    = req_valid & req_ready;
        instr_valid = enable & (count_q != '0);
        pop         = instr_valid & instr_ready & ~redirect_valid;
        rsp_drop    = (drop_cnt_q != '0);
        push        = rsp_valid & ~rsp_drop & ~redirect_valid;
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        drop_cnt_d    = drop_cnt_q;
        count_d       = count_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        outstanding_d = outstanding_q + OW'(req_fire) - OW'(rsp_valid);

        if (redirect_valid) begin
            // Everything still in flight belongs to the old path.
            fetch_pc_d = redirect_pc;
            rsp_pc_d   = redirect_pc;
            drop_cnt_d = outstanding_q - OW'(rsp_valid);
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            if (rsp_valid) begin
                if (rsp_drop) begin
                    drop_cnt_d = drop_cnt_q - OW'(1);
                end else begin
                    rsp_pc_d = rsp_pc_q + XLEN'(4);
                    wr_ptr_d = wr_ptr_q + PW'(1);
                end
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem_q[i] <= '0;
                pc_mem_q[i]    <= '0;
            end
        end else if (push) begin
            instr_mem_q[wr_ptr_q] <= rsp_data;
            pc_mem_q[wr_ptr_q]    <= rsp_pc_q;
        end
    end

    assign req_addr = fetch_pc_q;
    assign instr    = instr_mem_q[rd_ptr_q];
    assign instr_pc = pc_mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue: a memory with variable in-order latency plus an
// epoch-based model of which fetched words must reach the core.
module tb_fetch_queue;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable, req_valid, req_ready, rsp_valid, redirect_valid;
    logic        instr_valid, instr_ready;
    logic [31:0] req_addr, rsp_data, redirect_pc, instr, instr_pc;
    logic [2:0]  count;

    fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .req_ready      (req_ready),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .count          (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    logic [31:0] iq[$];
    logic [31:0] m_fetch_pc;
    int          m_epoch;
    int          cyc;
    int          last_due;
    int          n_checks = 0;
    int          n_errors = 0;

    int k_en, k_rr, k_ir, k_rd, k_rsp, max_lat;

    function automatic logic [31:0] word_of(input logic [31:0] pc);
        return {pc[15:0], pc[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        iq.delete();
        m_fetch_pc = RPC;
        m_epoch++;
        last_due = 0;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            logic        exp_req, exp_iv;
            int          live;
            mreq_t       h;
            @(posedge clk);
            #1;
            cyc++;
            enable         = ($urandom_range(99) < k_en);
            req_ready      = ($urandom_range(99) < k_rr);
            instr_ready    = ($urandom_range(99) < k_ir);
            redirect_valid = ($urandom_range(99) < k_rd);
            if ($urandom_range(3) == 0)
                redirect_pc = 32'hFFFF_FFF0 + {28'd0, 2'($urandom_range(3)), 2'b00};
            else
                redirect_pc = {20'd0, 10'($urandom_range(1023)), 2'b00};
            rsp_valid = (mq.size() > 0) && (mq[0].due <= cyc) && ($urandom_range(99) < k_rsp);
            rsp_data  = rsp_valid ? word_of(mq[0].addr) : 32'hDEAD_BEEF;
            #1;
            live = 0;
            foreach (mq[j]) if (mq[j].epoch == m_epoch) live++;
            exp_req = enable && !redirect_valid && (iq.size() + live < DEPTH);
            exp_iv  = enable && (iq.size() != 0);
            check("req_valid", 64'(req_valid), 64'(exp_req));
            check("req_addr", 64'(req_addr), 64'(m_fetch_pc));
            check("instr_valid", 64'(instr_valid), 64'(exp_iv));
            check("count", 64'(count), 64'(iq.size()));
            if (exp_iv) begin
                check("instr_pc", 64'(instr_pc), 64'(iq[0]));
                check("instr", 64'(instr), 64'(word_of(iq[0])));
            end
            if (rsp_valid) begin
                h = mq.pop_front();
                if (!redirect_valid && h.epoch == m_epoch) iq.push_back(h.addr);
            end
            if (!redirect_valid && exp_iv && instr_ready) void'(iq.pop_front());
            if (exp_req && req_ready) begin
                h.addr  = m_fetch_pc;
                h.epoch = m_epoch;
                h.due   = cyc + $urandom_range(max_lat, 1);
                if (h.due < last_due) h.due = last_due;
                last_due = h.due;
                mq.push_back(h);
                m_fetch_pc = m_fetch_pc + 32'd4;
            end
            if (redirect_valid) begin
                m_epoch++;
                iq.delete();
                m_fetch_pc = redirect_pc;
            end
        end
    endtask

    task automatic quiet_inputs();
        enable         = 1'b0;
        req_ready      = 1'b0;
        instr_ready    = 1'b0;
        rsp_valid      = 1'b0;
        rsp_data       = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_valid"}, 64'(req_valid), 64'd0);
        check({tag, "_instr_valid"}, 64'(instr_valid), 64'd0);
        check({tag, "_count"}, 64'(count), 64'd0);
        check({tag, "_instr"}, 64'(instr), 64'd0);
        check({tag, "_instr_pc"}, 64'(instr_pc), 64'd0);
        check({tag, "_req_addr"}, 64'(req_addr), 64'(RPC));
    endtask

    task automatic set_knobs(input int en, rr, ir, rd, rsp, lat);
        k_en = en; k_rr = rr; k_ir = ir; k_rd = rd; k_rsp = rsp; max_lat = lat;
    endtask

    initial begin
        cyc     = 0;
        m_epoch = 0;
        rst     = 1'b0;
        quiet_inputs();
        enable  = 1'b1;
        model_reset();
        #3;
        check_reset_outputs("por");
        #9 rst = 1'b1;
        enable = 1'b0;

        // Zero-wait memory and consumer: steady one-per-cycle issue.
        set_knobs(100, 100, 100, 0, 100, 1);
        run_cycles(30);

        // Stalled consumer: queue fills and requests stop.
        set_knobs(100, 100, 0, 0, 100, 2);
        run_cycles(20);
        check("fill_count", 64'(count), 64'(DEPTH));
        check("fill_req_valid", 64'(req_valid), 64'd0);

        set_knobs(85, 70, 60, 6, 75, 4);
        run_cycles(1500);

        // Refill, then reset asynchronously between clock edges.
        set_knobs(100, 100, 0, 0, 100, 2);
        run_cycles(20);
        check("prereset_count", 64'(count), 64'(DEPTH));
        #3;
        rst = 1'b0;
        quiet_inputs();
        #1;
        check_reset_outputs("mid");
        model_reset();
        repeat (3) @(posedge clk);
        #4 rst = 1'b1;

        set_knobs(100, 100, 100, 0, 100, 1);
        run_cycles(20);

        set_knobs(50, 80, 70, 10, 80, 3);
        run_cycles(800);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
